alu_seq: RTL and testbench
==========================

# alu_seq

The ALU sequencer is the initiator that drives the `alu` block. It accepts one operation at a time from the CPU-side valid/ready request channel and drives the ALU operand and select lines. It pulses the ALU's active-high start/reset, waits for the ALU `finished`, then returns the 32-bit result on a valid/ready response channel. It also watchdogs multi-cycle operations (multiply, divide) with a timeout and flags errors instead of hanging the pipeline.

## Interface
- `TIMEOUT`, default 48: maximum number of WAIT cycles before the operation is aborted; range 2..255.
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `r`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  sequencer can accept a request; high only in IDLE.
- `req_op`  in  2  0 = add, 1 = mul, 2 = div, 3 = nand (the ALU `s` encoding).
- `req_x`, `req_y`  in  32  operands.
- `rsp_valid`  out  1  response is present; high only in DONE.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  32  result.
- `rsp_err`  out  2  bit0 = timeout, bit1 = divide-by-zero.
- `alu_x`, `alu_y`  out  32  registered operands to the ALU.
- `alu_s`  out  2  registered select to the ALU.
- `alu_r`  out  1  active-high ALU start/reset.
- `alu_out`  in  32  ALU result.
- `alu_finished`  in  1  ALU completion.

## Operation
- The FSM has four states: IDLE, START, WAIT and DONE.
- **IDLE**
  - `req_ready`=1 and `alu_r`=1.
  - On `req_valid`&`req_ready`: latch `req_x`/`req_y`/`req_op` into `alu_x`/`alu_y`/`alu_s`, clear `rsp_err`, and go to START.
- **START**
  - `alu_r`=1 for exactly one cycle, which clears stale multiplier/divider state.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - `alu_r`=0.
  - Each cycle: if `alu_finished`=1, capture `alu_out` into `rsp_data` and go to DONE.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT`-1 without `alu_finished`, set `rsp_data`=0 and `rsp_err[0]`=1, then go to DONE.
  - If `alu_finished` and the timeout coincide, `alu_finished` wins: the result is returned with no error.
- **DONE**
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held stable.
  - `alu_r`=0, so the ALU output is not disturbed.
  - On `rsp_ready`: go to IDLE. There is no IDLE-bypass: a new request is accepted at the earliest one cycle later.
- **Width rules**
  - Results are exactly the ALU's 32 bits (mod 2^32).
  - The sequencer performs no arithmetic other than the 8-bit timeout counter, which saturates and never wraps.
- **Reset**
  - `r`=0 at any state, including mid-WAIT, forces IDLE on the next edge and discards any in-flight operation.
  - Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `alu_x`=`alu_y`=0, `alu_s`=0, `alu_r`=1, timeout counter=0.
- Request inputs are ignored outside IDLE. Response outputs must not change while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Accept edge E0 → START. E1 → WAIT. Earliest capture at E2 → `rsp_valid` high in the cycle after E2.
- Add and nand (ALU `finished` tied high): 3-cycle latency from accept to `rsp_valid`.
- Multiply: the ALU finishes after its 32-step counter, so `rsp_valid` follows about 33 WAIT cycles; the default `TIMEOUT` covers this.
- Back-to-back throughput is one operation per (latency + 1) cycles, with `rsp_ready` held high.
- `alu_r`, `req_ready` and `rsp_valid` are decoded from the state register and are glitch-free (Moore outputs).

## Configuration
- Macro: `ALU_SEQ_DIVZERO_EN`.
- **Defined:** in IDLE, a request with `req_op`=2 and `req_y`=0 is accepted and goes straight to DONE on the accept edge, with `rsp_data`=0 and `rsp_err[1]`=1. The ALU sees no `alu_r` pulse; `alu_s`/`alu_x`/`alu_y` still latch.
- **Undefined:** divide-by-zero is issued to the ALU like any other divide and is caught only by the timeout. `rsp_err[1]` is tied to 0.

## Structure
- Package `alu_seq_pkg` holds:
  - `alu_op_t` enum: ALU_ADD=0, ALU_MUL=1, ALU_DIV=2, ALU_NAND=3.
  - `alu_seq_state_t` enum: IDLE, START, WAIT, DONE.
  - Localparams ERR_TIMEOUT=0 and ERR_DIVZERO=1 (bit indices).
- One sub-module, `alu_seq_timer`: an 8-bit saturating counter with clear, enable and an `expired` compare against `TIMEOUT`-1.
- The top level holds the FSM and the operand/result registers.

## Test plan
- Add: x=0xFFFFFFFF, y=2, op=0, with an `alu_finished`=1 model → `rsp_data`=0x00000001, `rsp_err`=0, `rsp_valid` 3 cycles after accept; `alu_r` high exactly one cycle after accept.
- Multiply: x=7, y=6, op=1, with an ALU model that finishes after 33 cycles → `rsp_data`=42, `rsp_err`=0; `req_ready` stays low throughout.
- Timeout: `TIMEOUT`=8, op=1, ALU model never finishes → after 8 WAIT cycles `rsp_valid`=1, `rsp_data`=0, `rsp_err`=2'b01.
- Divide-by-zero with `ALU_SEQ_DIVZERO_EN`: x=10, y=0, op=2 → `rsp_valid` the cycle after accept, `rsp_err`=2'b10, no `alu_r` pulse. Without the macro, the same stimulus → `rsp_err`=2'b01 at timeout.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after an add → `rsp_data`/`rsp_err` stable and `req_ready`=0; a second request presented meanwhile is not accepted until the cycle after the handshake.
- Reset mid-multiply: drive `r`=0 for 1 cycle at WAIT cycle 10 → next cycle IDLE, `rsp_valid`=0, `alu_r`=1, `rsp_data`=0. No response is ever produced for the aborted op.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU opcode, sequencer state and error-bit definitions
package alu_seq_pkg;
   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_MUL  = 2'd1,
      ALU_DIV  = 2'd2,
      ALU_NAND = 2'd3
   } alu_op_t;
   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      DONE
   } alu_seq_state_t;
   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_DIVZERO = 1;
endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: 8-bit saturating watchdog counter that flags expiry at TIMEOUT-1
module alu_seq_timer #(
   parameter int TIMEOUT = 48
) (
   input  logic clk,
   input  logic r,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
   // count enabled cycles, holding at the top value instead of wrapping
   always_ff @(posedge clk)
      if (!r || clr) cnt <= '0;
      else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
   assign expired = cnt == LIMIT;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: request/response sequencer driving the alu block with a timeout watchdog; ALU_SEQ_DIVZERO_EN short-circuits divide-by-zero
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int TIMEOUT = 48
) (
   input  logic        clk,
   input  logic        r,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_x,
   input  logic [31:0] req_y,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_err,
   output logic [31:0] alu_x,
   output logic [31:0] alu_y,
   output logic [1:0]  alu_s,
   output logic        alu_r,
   input  logic [31:0] alu_out,
   input  logic        alu_finished
);
   alu_seq_state_t state, state_n;
   logic accept, divzero, expired;
   assign accept = req_valid && state == IDLE;
`ifdef ALU_SEQ_DIVZERO_EN
   assign divzero = req_op == ALU_DIV && req_y == '0;
`else
   assign divzero = 1'b0;
`endif
   assign req_ready = state == IDLE;
   assign rsp_valid = state == DONE;
   assign alu_r     = state == IDLE || state == START;
   alu_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .r       (r),
      .clr     (state == START),
      .en      (state == WAIT && !alu_finished),
      .expired (expired)
   );
   // state register
   always_ff @(posedge clk)
      if (!r) state <= IDLE;
      else state <= state_n;
   // next-state decode; a finished ALU takes priority over an expiring timer
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (accept) state_n = divzero ? DONE : START;
         START: state_n = WAIT;
         WAIT:  if (alu_finished || expired) state_n = DONE;
         DONE:  if (rsp_ready) state_n = IDLE;
      endcase
   end
   // operand latch on accept, result/error capture when leaving WAIT
   always_ff @(posedge clk)
      if (!r) begin
         alu_x    <= '0;
         alu_y    <= '0;
         alu_s    <= '0;
         rsp_data <= '0;
         rsp_err  <= '0;
      end else if (accept) begin
         alu_x                <= req_x;
         alu_y                <= req_y;
         alu_s                <= req_op;
         rsp_data             <= divzero ? '0 : rsp_data;
         rsp_err[ERR_TIMEOUT] <= 1'b0;
         rsp_err[ERR_DIVZERO] <= divzero;
      end else if (state == WAIT && alu_finished) begin
         rsp_data <= alu_out;
      end else if (state == WAIT && expired) begin
         rsp_data             <= '0;
         rsp_err[ERR_TIMEOUT] <= 1'b1;
      end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (default TIMEOUT instance plus a TIMEOUT=8 instance with a hung ALU)
module tb_alu_seq;
   logic clk = 1'b0;
   logic r, req_valid, req_valid8, rsp_ready, rsp_ready8;
   logic [1:0] req_op;
   logic [31:0] req_x, req_y;
   logic req_ready, rsp_valid, alu_r, alu_finished;
   logic [31:0] rsp_data, alu_x, alu_y, alu_out;
   logic [1:0] rsp_err, alu_s;
   logic req_ready8, rsp_valid8, alu_r8;
   logic [31:0] rsp_data8, alu_x8, alu_y8;
   logic [1:0] rsp_err8, alu_s8;
   logic [5:0] mcnt;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   alu_seq u_dut (
      .clk(clk), .r(r), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s),
      .alu_r(alu_r), .alu_out(alu_out), .alu_finished(alu_finished)
   );
   alu_seq #(.TIMEOUT(8)) u_dut8 (
      .clk(clk), .r(r), .req_valid(req_valid8), .req_ready(req_ready8), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8),
      .rsp_data(rsp_data8), .rsp_err(rsp_err8), .alu_x(alu_x8), .alu_y(alu_y8), .alu_s(alu_s8),
      .alu_r(alu_r8), .alu_out(32'h0), .alu_finished(1'b0)
   );
   // ALU model: add/nand finish at once, mul/div after 33 cycles out of reset, div by zero hangs
   always @(posedge clk) mcnt <= alu_r ? 6'd0 : (mcnt == 6'd63 ? mcnt : mcnt + 6'd1);
   always_comb begin
      alu_finished = 1'b0;
      alu_out = '0;
      case (alu_s)
         2'd0: begin alu_finished = 1'b1; alu_out = alu_x + alu_y; end
         2'd1: begin alu_finished = mcnt >= 6'd32; alu_out = alu_x * alu_y; end
         2'd2: begin alu_finished = alu_y != 0 && mcnt >= 6'd32; alu_out = alu_y != 0 ? alu_x / alu_y : 32'h0; end
         default: begin alu_finished = 1'b1; alu_out = ~(alu_x & alu_y); end
      endcase
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_rsp(input int max, output int n);
      n = 0;
      while (!rsp_valid && n < max) begin step(); n++; end
   endtask
   task automatic wait_rsp8(input int max, output int n);
      n = 0;
      while (!rsp_valid8 && n < max) begin step(); n++; end
   endtask
   task automatic handshake();
      rsp_ready = 1'b1;
      rsp_ready8 = 1'b1;
      step();
      rsp_ready = 1'b0;
      rsp_ready8 = 1'b0;
   endtask
   task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask
   task automatic test_reset();
      r = 1'b0;
      step(); step();
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      tests++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      tests++; if (rsp_err !== 2'b00) begin fails++; $display("FAIL reset_rsp_err got %b want 00", rsp_err); end
      tests++; if ({alu_x, alu_y, alu_s} !== 66'h0) begin fails++; $display("FAIL reset_alu_regs got %h/%h/%h want 0", alu_x, alu_y, alu_s); end
      tests++; if (alu_r !== 1'b1) begin fails++; $display("FAIL reset_alu_r got %b want 1", alu_r); end
      tests++; if (req_ready8 !== 1'b1 || rsp_valid8 !== 1'b0) begin fails++; $display("FAIL reset_dut8 got ready=%b valid=%b want 1/0", req_ready8, rsp_valid8); end
      r = 1'b1;
      step();
   endtask
   task automatic test_add();
      issue(2'd0, 32'hFFFF_FFFF, 32'd2);
      tests++; if (alu_r !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL add_start got r=%b rdy=%b vld=%b want 1/0/0", alu_r, req_ready, rsp_valid); end
      tests++; if (alu_x !== 32'hFFFF_FFFF || alu_y !== 32'd2 || alu_s !== 2'd0) begin fails++; $display("FAIL add_latch got %h/%h/%h want ffffffff/2/0", alu_x, alu_y, alu_s); end
      step();
      tests++; if (alu_r !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL add_wait got r=%b vld=%b want 0/0", alu_r, rsp_valid); end
      step();
      tests++; if (rsp_valid !== 1'b1 || alu_r !== 1'b0) begin fails++; $display("FAIL add_latency got vld=%b r=%b want 1/0", rsp_valid, alu_r); end
      tests++; if (rsp_data !== 32'h1 || rsp_err !== 2'b00) begin fails++; $display("FAIL add_result got %h err=%b want 00000001 err=00", rsp_data, rsp_err); end
      handshake();
      tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL add_release got rdy=%b vld=%b want 1/0", req_ready, rsp_valid); end
   endtask
   task automatic test_nand();
      int n;
      issue(2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_rsp(10, n);
      tests++; if (n !== 2) begin fails++; $display("FAIL nand_latency got %0d want 2", n); end
      tests++; if (rsp_data !== 32'h0FFF_0FFF || rsp_err !== 2'b00) begin fails++; $display("FAIL nand_result got %h err=%b want 0fff0fff err=00", rsp_data, rsp_err); end
      handshake();
   endtask
   task automatic test_mul();
      int n;
      bit rdy_seen = 0;
      issue(2'd1, 32'd7, 32'd6);
      n = 0;
      while (!rsp_valid && n < 60) begin
         if (req_ready) rdy_seen = 1;
         step();
         n++;
      end
      tests++; if (n !== 34) begin fails++; $display("FAIL mul_latency got %0d want 34", n); end
      tests++; if (rdy_seen !== 1'b0) begin fails++; $display("FAIL mul_req_ready got high want low"); end
      tests++; if (rsp_data !== 32'd42 || rsp_err !== 2'b00) begin fails++; $display("FAIL mul_result got %0d err=%b want 42 err=00", rsp_data, rsp_err); end
      handshake();
   endtask
   task automatic test_timeout();
      int n;
      req_op = 2'd1; req_x = 32'd7; req_y = 32'd6; req_valid8 = 1'b1;
      step();
      req_valid8 = 1'b0;
      tests++; if (alu_r8 !== 1'b1 || req_ready8 !== 1'b0) begin fails++; $display("FAIL tmo_start got r=%b rdy=%b want 1/0", alu_r8, req_ready8); end
      wait_rsp8(30, n);
      tests++; if (n !== 9) begin fails++; $display("FAIL tmo_latency got %0d want 9", n); end
      tests++; if (rsp_data8 !== 32'h0 || rsp_err8 !== 2'b01) begin fails++; $display("FAIL tmo_result got %h err=%b want 0 err=01", rsp_data8, rsp_err8); end
      handshake();
   endtask
   task automatic test_divzero();
`ifdef ALU_SEQ_DIVZERO_EN
      issue(2'd2, 32'd10, 32'd0);
      tests++; if (rsp_valid !== 1'b1 || alu_r !== 1'b0) begin fails++; $display("FAIL dz_fast got vld=%b r=%b want 1/0", rsp_valid, alu_r); end
      tests++; if (rsp_err !== 2'b10 || rsp_data !== 32'h0) begin fails++; $display("FAIL dz_result got %h err=%b want 0 err=10", rsp_data, rsp_err); end
      tests++; if (alu_x !== 32'd10 || alu_y !== 32'd0 || alu_s !== 2'd2) begin fails++; $display("FAIL dz_latch got %h/%h/%h want a/0/2", alu_x, alu_y, alu_s); end
      handshake();
`else
      int n;
      req_op = 2'd2; req_x = 32'd10; req_y = 32'd0; req_valid8 = 1'b1;
      step();
      req_valid8 = 1'b0;
      wait_rsp8(30, n);
      tests++; if (n !== 9) begin fails++; $display("FAIL dz_latency got %0d want 9", n); end
      tests++; if (rsp_err8 !== 2'b01 || rsp_data8 !== 32'h0) begin fails++; $display("FAIL dz_result got %h err=%b want 0 err=01", rsp_data8, rsp_err8); end
      handshake();
`endif
   endtask
   task automatic test_backpressure();
      int n;
      issue(2'd0, 32'd5, 32'd3);
      wait_rsp(10, n);
      req_op = 2'd0; req_x = 32'd100; req_y = 32'd1; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_err !== 2'b00 || req_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got vld=%b %h err=%b rdy=%b want 1 8 00 0", i, rsp_valid, rsp_data, rsp_err, req_ready); end
         step();
      end
      handshake();
      tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_x !== 32'd5) begin fails++; $display("FAIL bp_no_bypass got rdy=%b vld=%b x=%h want 1/0/5", req_ready, rsp_valid, alu_x); end
      step();
      req_valid = 1'b0;
      tests++; if (alu_x !== 32'd100 || alu_r !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL bp_second_accept got x=%h r=%b rdy=%b want 64/1/0", alu_x, alu_r, req_ready); end
      wait_rsp(10, n);
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd101) begin fails++; $display("FAIL bp_second_result got vld=%b %0d want 1 101", rsp_valid, rsp_data); end
      handshake();
   endtask
   task automatic test_reset_mid();
      bit rsp_seen = 0;
      issue(2'd1, 32'd7, 32'd6);
      for (int i = 0; i < 10; i++) step();
      tests++; if (alu_r !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_in_wait got r=%b vld=%b rdy=%b want 0/0/0", alu_r, rsp_valid, req_ready); end
      r = 1'b0;
      step();
      r = 1'b1;
      tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_r !== 1'b1) begin fails++; $display("FAIL rst_mid_idle got rdy=%b vld=%b r=%b want 1/0/1", req_ready, rsp_valid, alu_r); end
      tests++; if (rsp_data !== 32'h0 || alu_x !== 32'h0) begin fails++; $display("FAIL rst_mid_clear got data=%h x=%h want 0/0", rsp_data, alu_x); end
      rsp_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) rsp_seen = 1;
         step();
      end
      rsp_ready = 1'b0;
      tests++; if (rsp_seen !== 1'b0) begin fails++; $display("FAIL rst_mid_no_rsp got response want none"); end
   endtask
   initial begin
      r = 1'b0; req_valid = 1'b0; req_valid8 = 1'b0; rsp_ready = 1'b0; rsp_ready8 = 1'b0;
      req_op = 2'd0; req_x = '0; req_y = '0;
      test_reset();
      test_add();
      test_nand();
      test_mul();
      test_timeout();
      test_divzero();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
